// File: rtl/priority_grant_arbiter.sv
// priority_grant_arbiter
//   Three-requester fixed-priority arbiter. req[0] has the highest priority.
//   A grant is held until the holder pulses done, or until the hold counter
//   expires, which forces a release and raises a one-cycle timeout pulse.
//   After every release there is at least one idle cycle before the next grant.
//
//   Optional feature (macro MULTI_MATCH_CHECK_EN):
//     When defined, multi_match pulses in the first grant cycle if two or more
//     requests were present at arbitration. multi_cnt counts those events and
//     saturates at 255. When undefined, both outputs are tied to 0.
//
// Parameters
//   DW       data width per requester
//   TIMEOUT  maximum number of BUSY cycles before a forced release (2..255)
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   req[2:0]     request flags
//   din[3*DW-1:0] requester data; requester i uses din[i*DW +: DW]
//   done         release strobe from the holder (ignored in IDLE)
//   gnt[2:0]     one-hot grant
//   gnt_valid    high whenever gnt is nonzero
//   dout[DW-1:0] data captured from the granted requester
//   timeout      one-cycle pulse on a forced release
//   multi_match  one-cycle pulse on a contended arbitration
//   multi_cnt[7:0] saturating count of contended arbitrations
module priority_grant_arbiter #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [3*DW-1:0] din,
  input  logic            done,
  output logic [2:0]      gnt,
  output logic            gnt_valid,
  output logic [DW-1:0]   dout,
  output logic            timeout,
  output logic            multi_match,
  output logic [7:0]      multi_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [2:0]      gnt_next;
  logic [DW-1:0]   dout_next;
  logic [7:0]      hold_cnt;
  logic [7:0]      hold_next;
  logic            timeout_next;

  logic [2:0]      pick;
  logic [DW-1:0]   pick_data;
  logic            arb_fire;
  logic            hold_expired;

  // Fixed-priority select: lowest set index wins.
  always_comb begin
    pick      = '0;
    pick_data = '0;
    if (req[0]) begin
      pick      = 3'b001;
      pick_data = din[0*DW +: DW];
    end else if (req[1]) begin
      pick      = 3'b010;
      pick_data = din[1*DW +: DW];
    end else if (req[2]) begin
      pick      = 3'b100;
      pick_data = din[2*DW +: DW];
    end
  end

  assign arb_fire     = (state == IDLE) && (req != 3'b000);
  assign hold_expired = (hold_cnt == 8'(TIMEOUT - 1));

  // State register plus the registered datapath it controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      dout     <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      dout     <= dout_next;
      hold_cnt <= hold_next;
      timeout  <= timeout_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req != 3'b000) state_next = BUSY;
      BUSY: if (done || hold_expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values. done takes precedence over expiry so a
  // coincident release never reports a timeout.
  always_comb begin
    gnt_next     = gnt;
    dout_next    = dout;
    hold_next    = hold_cnt;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != 3'b000) begin
          gnt_next  = pick;
          dout_next = pick_data;
          hold_next = '0;
        end
      end
      BUSY: begin
        if (done) begin
          gnt_next = '0;
        end else if (hold_expired) begin
          gnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
      end
      default: gnt_next = '0;
    endcase
  end

  assign gnt_valid = (gnt != 3'b000);

`ifdef MULTI_MATCH_CHECK_EN
  logic contended;

  // popcount(req) >= 2 for a 3-bit vector
  assign contended = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      multi_match <= 1'b0;
      multi_cnt   <= '0;
    end else begin
      multi_match <= arb_fire && contended;
      if (arb_fire && contended && (multi_cnt != 8'hFF)) begin
        multi_cnt <= multi_cnt + 8'd1;
      end
    end
  end
`else
  assign multi_match = 1'b0;
  assign multi_cnt   = '0;
`endif

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// tb_priority_grant_arbiter
//   Directed self-checking bench for priority_grant_arbiter (DW=8, TIMEOUT=4).
//   Works with MULTI_MATCH_CHECK_EN either defined or undefined.
module tb_priority_grant_arbiter;

  localparam int DW = 8;

`ifdef MULTI_MATCH_CHECK_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [2:0]      req;
  logic [3*DW-1:0] din;
  logic            done;
  logic [2:0]      gnt;
  logic            gnt_valid;
  logic [DW-1:0]   dout;
  logic            timeout;
  logic            multi_match;
  logic [7:0]      multi_cnt;

  int unsigned passed;
  int unsigned total;

  priority_grant_arbiter #(.DW(DW), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .din         (din),
    .done        (done),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .dout        (dout),
    .timeout     (timeout),
    .multi_match (multi_match),
    .multi_cnt   (multi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_grant();
    req  = 3'b000;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; din = '0; done = 1'b0;
    tick(); tick();
    total++; if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b expected 000", gnt); else passed++;
    total++; if (gnt_valid !== 1'b0) $display("FAIL reset_gnt_valid: got %b expected 0", gnt_valid); else passed++;
    total++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout); else passed++;
    total++; if (multi_match !== 1'b0) $display("FAIL reset_multi_match: got %b expected 0", multi_match); else passed++;
    total++; if (multi_cnt !== 8'd0) $display("FAIL reset_multi_cnt: got %0d expected 0", multi_cnt); else passed++;
    rst = 1'b0;
    tick();
    total++; if (gnt !== 3'b000) $display("FAIL idle_no_req_gnt: got %b expected 000", gnt); else passed++;
  endtask

  task automatic test_single();
    req = 3'b010;
    din = {8'd0, 8'd5, 8'd0};
    tick();
    total++; if (gnt !== 3'b010) $display("FAIL single_gnt: got %b expected 010", gnt); else passed++;
    total++; if (gnt_valid !== 1'b1) $display("FAIL single_gnt_valid: got %b expected 1", gnt_valid); else passed++;
    total++; if (dout !== 8'd5) $display("FAIL single_dout: got %0d expected 5", dout); else passed++;
    total++; if (multi_match !== 1'b0) $display("FAIL single_multi_match: got %b expected 0", multi_match); else passed++;
    release_grant();
    total++; if (gnt !== 3'b000) $display("FAIL single_release_gnt: got %b expected 000", gnt); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL single_release_timeout: got %b expected 0", timeout); else passed++;
  endtask

  task automatic test_overlap_hold();
    req = 3'b111;
    din = {8'd6, 8'd5, 8'd4};
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL overlap_gnt: got %b expected 001", gnt); else passed++;
    total++; if (dout !== 8'd4) $display("FAIL overlap_dout: got %0d expected 4", dout); else passed++;
    total++; if (multi_match !== MM) $display("FAIL overlap_multi_match: got %b expected %b", multi_match, MM); else passed++;
    total++; if (multi_cnt !== 8'(MM)) $display("FAIL overlap_multi_cnt: got %0d expected %0d", multi_cnt, MM); else passed++;
    // Change inputs during BUSY: grant and data must stay frozen.
    req = 3'b100;
    din = {8'd6, 8'd9, 8'd9};
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL hold_gnt: got %b expected 001", gnt); else passed++;
    total++; if (dout !== 8'd4) $display("FAIL hold_dout: got %0d expected 4", dout); else passed++;
    total++; if (multi_match !== 1'b0) $display("FAIL hold_multi_match: got %b expected 0", multi_match); else passed++;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 3'b000) $display("FAIL gap_gnt: got %b expected 000", gnt); else passed++;
    total++; if (gnt_valid !== 1'b0) $display("FAIL gap_gnt_valid: got %b expected 0", gnt_valid); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL gap_timeout: got %b expected 0", timeout); else passed++;
    tick();
    total++; if (gnt !== 3'b100) $display("FAIL regrant_gnt: got %b expected 100", gnt); else passed++;
    total++; if (dout !== 8'd6) $display("FAIL regrant_dout: got %0d expected 6", dout); else passed++;
    total++; if (multi_cnt !== 8'(MM)) $display("FAIL regrant_multi_cnt: got %0d expected %0d", multi_cnt, MM); else passed++;
    release_grant();
  endtask

  task automatic test_timeout();
    req = 3'b001;
    din = {8'd0, 8'd0, 8'h11};
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL to_grant: got %b expected 001", gnt); else passed++;
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (gnt !== 3'b001) $display("FAIL to_hold%0d_gnt: got %b expected 001", i, gnt); else passed++;
      total++; if (timeout !== 1'b0) $display("FAIL to_hold%0d_timeout: got %b expected 0", i, timeout); else passed++;
    end
    tick();
    total++; if (gnt !== 3'b000) $display("FAIL to_release_gnt: got %b expected 000", gnt); else passed++;
    total++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b expected 1", timeout); else passed++;
    tick();
    total++; if (timeout !== 1'b0) $display("FAIL to_pulse_end: got %b expected 0", timeout); else passed++;
    total++; if (gnt !== 3'b000) $display("FAIL to_after_gnt: got %b expected 000", gnt); else passed++;
  endtask

  task automatic test_done_at_timeout();
    req = 3'b010;
    din = {8'd0, 8'h22, 8'd0};
    tick();
    req = 3'b000;
    tick(); tick(); tick();
    total++; if (gnt !== 3'b010) $display("FAIL dto_hold_gnt: got %b expected 010", gnt); else passed++;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 3'b000) $display("FAIL dto_gnt: got %b expected 000", gnt); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL dto_timeout: got %b expected 0", timeout); else passed++;
    tick();
    total++; if (timeout !== 1'b0) $display("FAIL dto_timeout_late: got %b expected 0", timeout); else passed++;
  endtask

  task automatic test_done_idle();
    req  = 3'b000;
    done = 1'b1;
    tick();
    total++; if (gnt !== 3'b000) $display("FAIL done_idle_gnt: got %b expected 000", gnt); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL done_idle_timeout: got %b expected 0", timeout); else passed++;
    done = 1'b0;
    req  = 3'b100;
    din  = {8'h33, 8'd0, 8'd0};
    tick();
    total++; if (gnt !== 3'b100) $display("FAIL done_idle_grant: got %b expected 100", gnt); else passed++;
    total++; if (dout !== 8'h33) $display("FAIL done_idle_dout: got %h expected 33", dout); else passed++;
    release_grant();
  endtask

  task automatic test_rst_busy();
    req = 3'b011;
    din = {8'd0, 8'h44, 8'h55};
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL rstb_grant: got %b expected 001", gnt); else passed++;
    rst = 1'b1;
    tick();
    total++; if (gnt !== 3'b000) $display("FAIL rstb_gnt: got %b expected 000", gnt); else passed++;
    total++; if (gnt_valid !== 1'b0) $display("FAIL rstb_gnt_valid: got %b expected 0", gnt_valid); else passed++;
    total++; if (dout !== 8'h00) $display("FAIL rstb_dout: got %h expected 00", dout); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL rstb_timeout: got %b expected 0", timeout); else passed++;
    total++; if (multi_match !== 1'b0) $display("FAIL rstb_multi_match: got %b expected 0", multi_match); else passed++;
    total++; if (multi_cnt !== 8'd0) $display("FAIL rstb_multi_cnt: got %0d expected 0", multi_cnt); else passed++;
    rst = 1'b0;
    tick();
    total++; if (gnt !== 3'b001) $display("FAIL rstb_first_arb_gnt: got %b expected 001", gnt); else passed++;
    total++; if (dout !== 8'h55) $display("FAIL rstb_first_arb_dout: got %h expected 55", dout); else passed++;
    total++; if (multi_cnt !== 8'(MM)) $display("FAIL rstb_first_arb_cnt: got %0d expected %0d", multi_cnt, MM); else passed++;
    release_grant();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      req = 3'b111;
      din = {8'd3, 8'd2, 8'd1};
      tick();
      if (i == 254) begin
        total++; if (multi_cnt !== (MM ? 8'd254 : 8'd0)) $display("FAIL sat_254: got %0d expected %0d", multi_cnt, MM ? 254 : 0); else passed++;
      end
      release_grant();
    end
    total++; if (multi_cnt !== (MM ? 8'd255 : 8'd0)) $display("FAIL sat_final: got %0d expected %0d", multi_cnt, MM ? 255 : 0); else passed++;
    total++; if (gnt !== 3'b000) $display("FAIL sat_gnt: got %b expected 000", gnt); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst  = 1'b1;
    req  = 3'b000;
    din  = '0;
    done = 1'b0;
    test_reset();
    test_single();
    test_overlap_hold();
    test_timeout();
    test_done_at_timeout();
    test_done_idle();
    test_rst_busy();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
